// File: rtl/tlul_mem_responder_if.sv
// ---------------------------------------------------------------------------
// tlul_mem_responder_if
//
// TL-UL A/D channel bundle between a host (master) and a device (slave).
//
// Handshake semantics (both channels): a beat transfers on a rising clock
// edge where valid && ready are both high. Once valid is raised the sender
// holds valid and every payload field stable until that transfer edge.
// ready may change freely and never depends on valid from the same side.
//
// Signals
//   A channel (host -> device): a_valid, a_opcode, a_param, a_size,
//                               a_source, a_address, a_mask, a_data
//                               a_ready (device -> host)
//   D channel (device -> host): d_valid, d_opcode, d_param, d_size,
//                               d_source, d_sink, d_data, d_user, d_error
//                               d_ready (host -> device)
//
// Modports
//   master : host side (drives A payload and d_ready)
//   slave  : device side (drives D payload and a_ready)
// ---------------------------------------------------------------------------
interface tlul_mem_responder_if;
    // A channel
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;

    // D channel
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        d_ready;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_data, d_user, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_data, d_user, d_error
    );
endinterface

// File: rtl/tlul_mem_responder.sv
// ---------------------------------------------------------------------------
// tlul_mem_responder
//
// TL-UL device-side responder backed by a word-addressed register array.
// Services Get, PutFullData and PutPartialData; every accepted A beat
// produces exactly one D beat, queued in a 2-entry response FIFO so the
// D channel can be backpressured without losing responses.
//
// Parameters
//   Depth    : number of 32-bit words (power of two, >= 2)
//   BaseAddr : byte base address, aligned to Depth*4
//   InitZero : 1 -> array cleared by reset, 0 -> array not reset
//
// Ports
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   tl        : TL-UL bundle, slave modport (A request in, D response out)
//   err_cnt_o : saturating count of accepted beats answered with d_error
//               (only present when TLUL_RESP_ERR_CNT_EN is defined)
//
// Optional feature macro: TLUL_RESP_ERR_CNT_EN
// ---------------------------------------------------------------------------
module tlul_mem_responder #(
    parameter int unsigned Depth    = 256,
    parameter logic [31:0] BaseAddr = 32'h0010_0000,
    parameter bit          InitZero = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tlul_mem_responder_if.slave  tl
`ifdef TLUL_RESP_ERR_CNT_EN
    ,
    output logic [15:0]          err_cnt_o
`endif
);

    localparam int unsigned IdxW       = $clog2(Depth);
    localparam logic [31:0] RegionMask = 32'(Depth * 4) - 32'd1;

    // A-channel opcodes
    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    // One queued response; only the fields that vary per beat are stored.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              ready_q;     // low during reset and the cycle it releases
    logic [1:0]        fifo_cnt_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    rsp_t              fifo_q [2];
    logic [31:0]       mem_q  [Depth];

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic a_ready;
    logic a_fire;
    logic d_fire;

    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign a_ready    = ready_q && !fifo_full;
    assign a_fire     = tl.a_valid && a_ready;
    assign d_fire     = !fifo_empty && tl.d_ready;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic [IdxW-1:0] word_idx;
    logic            in_range;
    logic            misaligned;
    logic            is_get;
    logic            is_put_full;
    logic            is_put_part;
    logic            bad_opcode;
    logic            put_full_viol;
    logic            size_too_big;
    logic            req_err;
    logic            do_write;

    assign word_idx      = tl.a_address[IdxW+1:2];
    assign in_range      = ((tl.a_address & ~RegionMask) == BaseAddr);
    assign is_get        = (tl.a_opcode == OpGet);
    assign is_put_full   = (tl.a_opcode == OpPutFull);
    assign is_put_part   = (tl.a_opcode == OpPutPartial);
    assign bad_opcode    = !(is_get || is_put_full || is_put_part);
    assign size_too_big  = (tl.a_size == 2'd3);
    assign put_full_viol = is_put_full && ((tl.a_mask != 4'hF) || (tl.a_size != 2'd2));

    // Alignment is relative to the access size; size 3 is already an error
    // so its alignment is irrelevant.
    always_comb begin
        misaligned = 1'b0;
        case (tl.a_size)
            2'd1:    misaligned = tl.a_address[0];
            2'd2:    misaligned = |tl.a_address[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err  = !in_range || size_too_big || misaligned || bad_opcode || put_full_viol;
    assign do_write = a_fire && !req_err && (is_put_full || is_put_part);

    // Response built in the acceptance cycle. The array is read
    // combinationally, so a write accepted in an earlier cycle is already
    // visible to this read.
    rsp_t rsp_new;

    always_comb begin
        rsp_new        = '0;
        rsp_new.size   = tl.a_size;
        rsp_new.source = tl.a_source;
        rsp_new.error  = req_err;
        if (is_get) begin
            rsp_new.opcode = OpAccessAckData;
            rsp_new.data   = req_err ? 32'hFFFF_FFFF : mem_q[word_idx];
        end else begin
            rsp_new.opcode = OpAccessAck;
            rsp_new.data   = 32'h0;
        end
    end

    // -----------------------------------------------------------------------
    // Register array (byte-masked write on the acceptance edge)
    // -----------------------------------------------------------------------
    generate
        if (InitZero) begin : g_mem_reset
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < int'(Depth); i++) begin
                        mem_q[i] <= 32'h0;
                    end
                end else if (do_write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (tl.a_mask[b]) begin
                            mem_q[word_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
                        end
                    end
                end
            end
        end else begin : g_mem_noreset
            always_ff @(posedge clk_i) begin
                if (do_write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (tl.a_mask[b]) begin
                            mem_q[word_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Response FIFO (2 entries, 1-bit wrapping pointers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q    <= 1'b0;
            fifo_cnt_q <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            ready_q <= 1'b1;
            if (a_fire) begin
                fifo_q[wr_ptr_q] <= rsp_new;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (d_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Push while full cannot happen (a_ready is low), so the count
            // never exceeds 2; push+pop together leaves it unchanged.
            case ({a_fire, d_fire})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Payload is forced to zero when no response is pending so an
    // idle D channel carries no stale data.
    // -----------------------------------------------------------------------
    rsp_t head;

    assign head = fifo_empty ? '0 : fifo_q[rd_ptr_q];

    assign tl.a_ready  = a_ready;
    assign tl.d_valid  = !fifo_empty;
    assign tl.d_opcode = head.opcode;
    assign tl.d_param  = 3'd0;
    assign tl.d_size   = head.size;
    assign tl.d_source = head.source;
    assign tl.d_sink   = 1'b0;
    assign tl.d_data   = head.data;
    assign tl.d_user   = 14'd0;
    assign tl.d_error  = head.error;

    // a_param carries no meaning for the supported opcodes.
    logic unused_a_param;
    assign unused_a_param = ^tl.a_param;

    // -----------------------------------------------------------------------
    // Optional saturating error counter
    // -----------------------------------------------------------------------
`ifdef TLUL_RESP_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= 16'd0;
        end else if (a_fire && req_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule
